// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes (F3_*)
//   - FSM state encoding (IDLE/REQ/DONE)
//   - lane_mask(): byte-lane enables for a given access size and byte offset
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // size is funct3[1:0]: 00 byte, 01 halfword, 10 word.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return 4'b0011 << {addr_lo[1], 1'b0};
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational formatting for the load/store unit.
//   i_store    : 1=store, 0=load (selects the legal funct3 set)
//   i_funct3   : RV32I width/sign code
//   i_addr_lo  : byte offset within the word
//   i_wdata    : right-justified store data
//   i_rword    : word read from memory
//   o_ok       : access is legal and naturally aligned
//   o_mask     : byte-lane enables
//   o_wdata    : lane-replicated store data
//   o_rdata    : extracted, sign/zero-extended load data
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic        o_ok,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic        w_legal;
    logic        w_aligned;
    logic [31:0] w_shift;

    always_comb begin
        if (i_store)
            w_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);
        else
            w_legal = (i_funct3 == F3_B)  || (i_funct3 == F3_H)  || (i_funct3 == F3_W) ||
                      (i_funct3 == F3_BU) || (i_funct3 == F3_HU);

        case (i_funct3[1:0])
            2'b01:   w_aligned = ~i_addr_lo[0];
            2'b10:   w_aligned = (i_addr_lo == 2'b00);
            default: w_aligned = 1'b1;
        endcase

        o_ok   = w_legal & w_aligned;
        o_mask = lane_mask(i_funct3[1:0], i_addr_lo);

        case (i_funct3[1:0])
            2'b00:   o_wdata = {4{i_wdata[7:0]}};
            2'b01:   o_wdata = {2{i_wdata[15:0]}};
            default: o_wdata = i_wdata;
        endcase

        w_shift = i_rword >> {i_addr_lo, 3'b000};
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_W:    o_rdata = i_rword;
            F3_BU:   o_rdata = {24'd0, w_shift[7:0]};
            F3_HU:   o_rdata = {16'd0, w_shift[15:0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store from the core, issues a
// word-addressed, byte-masked request to data memory, holds it until
// mem_valid, and returns aligned, extended load data with a done pulse.
// Misaligned/illegal accesses complete with core_fault and never reach memory.
// Ports: clk, rst (async active-low); core_* handshake from the execute
// stage; mem_* request/response to data memory.
// Optional: define LSU_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES
// cycles without mem_valid.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_store,
    input  logic [2:0]        core_funct3,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_ready,
    output logic              core_done,
    output logic [31:0]       core_rdata,
    output logic              core_fault,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out,
    input  logic              mem_valid
);

    lsu_state_t        r_state;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic              r_we;
    logic [3:0]        r_mask;
    logic [ADDR_W-1:0] r_address;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_fault;

    logic              w_idle;
    logic [2:0]        w_funct3;
    logic [1:0]        w_addr_lo;
    logic              w_ok;
    logic [3:0]        w_mask;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic              w_unused_addr;

`ifdef LSU_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] r_tcnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // One formatter is shared: it formats the incoming request while idle
    // and extracts load data from the registered request afterwards.
    assign w_idle    = (r_state == IDLE);
    assign w_funct3  = w_idle ? core_funct3    : r_funct3;
    assign w_addr_lo = w_idle ? core_addr[1:0] : r_addr_lo;

    lsu_align u_align (
        .i_store   (core_store),
        .i_funct3  (w_funct3),
        .i_addr_lo (w_addr_lo),
        .i_wdata   (core_wdata),
        .i_rword   (mem_data_out),
        .o_ok      (w_ok),
        .o_mask    (w_mask),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rdata)
    );

    assign w_unused_addr = ^core_addr[31:ADDR_W+2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_we      <= 1'b0;
            r_mask    <= '0;
            r_address <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_fault   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_tcnt    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (core_req) begin
                        r_funct3  <= core_funct3;
                        r_addr_lo <= core_addr[1:0];
                        if (w_ok) begin
                            r_we      <= core_store;
                            r_mask    <= w_mask;
                            r_address <= core_addr[ADDR_W+1:2];
                            r_wdata   <= w_wdata;
                            r_state   <= REQ;
`ifdef LSU_TIMEOUT_EN
                            r_tcnt    <= '0;
`endif
                        end else begin
                            r_fault <= 1'b1;
                            r_rdata <= '0;
                            r_state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (mem_valid) begin
                        r_rdata <= r_we ? '0 : w_rdata;
                        r_fault <= 1'b0;
                        r_state <= DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_rdata <= '0;
                        r_fault <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_rdata <= '0;
                    r_fault <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_ready  = w_idle;
    assign core_done   = (r_state == DONE);
    assign core_rdata  = r_rdata;
    assign core_fault  = r_fault;
    assign mem_request = (r_state == REQ);
    assign mem_we_re   = r_we;
    assign mem_mask    = r_mask;
    assign mem_address = r_address;
    assign mem_data_in = r_wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the core's execute stage and the data memory. Accepts one load or store per transaction from the core and formats it into a word-addressed, byte-masked memory request. Holds the request/valid handshake with the data memory until it completes, then returns aligned, sign- or zero-extended load data. Detects misaligned and illegal accesses before they reach memory.

Parameters:
ADDR_W, 12, word-address width driven to data memory (byte address bits [ADDR_W+1:2])
TIMEOUT_CYCLES, 255, wait-cycle limit before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
core_req  in  1  core requests a transaction; sampled only when core_ready=1
core_store  in  1  1=store, 0=load
core_funct3  in  3  RV32I width/sign code
core_addr  in  32  byte address (ALU result)
core_wdata  in  32  store data, right-justified
core_ready  out  1  unit idle, can accept a request
core_done  out  1  one-cycle pulse, transaction finished
core_rdata  out  32  load result, valid while core_done=1
core_fault  out  1  one-cycle pulse with core_done: misaligned, illegal or timed out
mem_request  out  1  data-memory request
mem_we_re  out  1  1=write, 0=read
mem_mask  out  4  byte-lane enables
mem_address  out  ADDR_W  word address = core_addr[ADDR_W+1:2]
mem_data_in  out  32  lane-replicated store data to memory
mem_data_out  in  32  read word from memory
mem_valid  in  1  memory completes the current request

Behaviour:
- Reset (rst low, asynchronous): state=IDLE. core_ready=1, core_done=0, core_fault=0, core_rdata=0, mem_request=0, mem_we_re=0, mem_mask=0, mem_address=0, mem_data_in=0. Reset mid-transaction drops mem_request immediately and abandons the transaction with no done pulse.
- States: IDLE, REQ, DONE.
- IDLE: core_ready=1. On core_req=1, register store flag, funct3, address and formatted data/mask.
  - Legal and aligned: go to REQ.
  - Otherwise: go to DONE with fault=1. No memory request is issued.
- Legality: funct3 loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores 000 SB, 001 SH, 010 SW. Every other code is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- REQ: mem_request=1. mem_we_re, mem_mask, mem_address and mem_data_in stay stable until mem_valid=1 is sampled. On that edge, latch extracted load data (stores latch 0) and go to DONE. mem_valid is ignored outside REQ.
- DONE: core_done=1 for exactly one cycle, core_ready=0, then IDLE. core_rdata and core_fault are valid only in DONE; core_rdata=0 and core_fault=0 otherwise.
- Latency: accept at edge T, request visible T..; if mem_valid in first REQ cycle, core_done in cycle T+2. Minimum throughput is one transaction per 3 cycles.
- Store format:
  - SB: byte replicated to all 4 lanes, mask=0001<<addr[1:0].
  - SH: halfword replicated to both halves, mask=0011<<{addr[1],0}.
  - SW: data unchanged, mask=1111.
- Load mask: same lane mask as the equivalent store width, with mem_we_re=0.
- Load extract: shift the word right by 8*addr[1:0]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend. LW returns the word unchanged.
- core_req while core_ready=0 is ignored. The core must hold its request until it sees core_ready.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: an 8+ bit counter (width from TIMEOUT_CYCLES) clears on entry to REQ and counts each REQ cycle without mem_valid. When it reaches TIMEOUT_CYCLES, drop mem_request and go to DONE with core_fault=1, core_rdata=0. If mem_valid arrives on the expiry cycle, valid wins and there is no fault.
- Undefined: REQ waits indefinitely; no counter logic is present.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state encoding: IDLE=2'd0, REQ=2'd1, DONE=2'd2.
  - lane-mask function.
- One combinational sub-module, lsu_align: store lane replication/mask generation and load extraction/extension. Used by the FSM top.

Test Plan:
- SB addr 0x0000_0103, wdata 0x0000_00A5 -> mem_mask=1000, mem_data_in=0xA5A5_A5A5, mem_address=0x040, mem_we_re=1; core_done at T+2 with mem_valid immediate.
- LB addr 0x2, mem word 0x80FF_1234 -> core_rdata=0xFFFF_FFFF; LBU same address -> 0x0000_00FF.
- LH addr 0x6, mem word 0x8001_0000 -> core_rdata=0xFFFF_8001; LHU -> 0x0000_8001.
- LW addr 0x5 or funct3=011 -> no mem_request ever, core_done and core_fault both high at T+1.
- mem_valid delayed 3 cycles -> mem_request/address/mask/data held stable; core_done at T+5. rst pulled low during REQ -> mem_request=0 asynchronously, no core_done.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_valid never asserted -> request drops after 4 REQ cycles, core_fault=1, core_rdata=0.
